fetch_queue: RTL

Parametrised successor of the single-register fetch stage.
- Holds the PC and drives instruction-memory address `imem_addr_F`.
- Captures each fetched `{pc, instr}` pair into a DEPTH-entry queue.
- Presents the queue head to decode with a valid/ready handshake, so decode back-pressure stalls the PC.
- A taken branch (`PCSrc_F`) redirects the PC and flushes all queued, wrong-path entries.

---
 rtl/fetch_queue_pkg.sv | 12 +
 rtl/fetch_queue_if.sv | 10 +
 rtl/fetch_fifo.sv | 57 +++++
 rtl/fetch_queue.sv | 86 ++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared constants and entry layout for the fetch queue.
// Optional FETCH_PERF_EN adds fetch/stall counters in fetch_queue.
package fetch_pkg;
  localparam int INSTR_W  = 32;
  localparam int PC_INC   = 4;
  localparam int FETCH_N  = 64;  // default PC width

  typedef struct packed {
    logic [FETCH_N-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode valid/ready channel carrying the queue head.
interface fetch_queue_if #(parameter int N = 64);
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr_out;
  logic [N-1:0] pc_out;

  modport master (output out_valid, output instr_out, output pc_out, input out_ready);
  modport slave  (input out_valid, input instr_out, input pc_out, output out_ready);
endinterface

// File: rtl/fetch_fifo.sv
// Generic circular buffer with synchronous flush; head is read combinationally.
// Caller must not push when full unless it also pops in the same cycle.
module fetch_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_pop;
  logic             w_push;

  assign empty  = (r_count == '0);
  assign full   = (r_count == CW'(DEPTH));
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);
  assign rdata  = r_mem[r_rptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (flush) begin
      // Entries are left stale; only the bookkeeping restarts.
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= wdata;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/fetch_queue.sv
// PC register plus DEPTH-entry fetch queue; branch redirect flushes the queue.
// Build option FETCH_PERF_EN adds saturating perf_fetched/perf_stalls counters.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          N        = 64,
  parameter int          DEPTH    = 4,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               PCSrc_F,
  input  logic [N-1:0]       PCBranch_F,
  output logic [N-1:0]       imem_addr_F,
  input  logic [INSTR_W-1:0] imem_rd_F,
  fetch_queue_if.master      dec
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stalls
`endif
);
  // Same layout as fetch_entry_t, generalised to this instance's PC width.
  typedef struct packed {
    logic [N-1:0]       pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [N-1:0] r_pc;
  logic         w_full;
  logic         w_empty;
  logic         w_pop;
  logic         w_push;
  entry_t       w_wr_entry;
  entry_t       w_head;

  assign imem_addr_F = r_pc;
  assign w_pop       = ~w_empty & dec.out_ready;
  assign w_push      = ~PCSrc_F & (~w_full | w_pop);

  assign w_wr_entry.pc    = r_pc;
  assign w_wr_entry.instr = imem_rd_F;

  fetch_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .flush (PCSrc_F),
    .wdata (w_wr_entry),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  assign dec.out_valid = ~w_empty;
  assign dec.instr_out = w_head.instr;
  assign dec.pc_out    = w_head.pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_pc <= RESET_PC;
    else if (PCSrc_F) r_pc <= {PCBranch_F[N-1:2], 2'b00};
    else if (w_push)  r_pc <= r_pc + N'(PC_INC);
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_fetched;
  logic [31:0] r_stalls;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetched <= '0;
      r_stalls  <= '0;
    end else begin
      if (w_push && r_fetched != '1) r_fetched <= r_fetched + 32'd1;
      if (!PCSrc_F && !w_push && r_stalls != '1) r_stalls <= r_stalls + 32'd1;
    end
  end

  assign perf_fetched = r_fetched;
  assign perf_stalls  = r_stalls;
`endif
endmodule
